// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-key FSM state encoding and a
// constant-width helper used to size the tick, agreement and hold counters.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_fsm_e;

  // Minimum 1 so that a counter sized from this is never zero bits wide.
  function automatic int CLOG2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: two-flop synchronizer, four-state agreement FSM
// and, when KEY_LONG_PRESS_EN is defined, a saturating hold counter.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 2,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int LONG_TICKS     = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int            CW       = CLOG2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic          PIN_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1_q, sync2_q;
  key_fsm_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // The second stage holds the normalised level (1 = pressed).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q ^ PIN_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        RELEASED: begin
          if (sync2_q) begin
            if (STABLE_SAMPLES == 1) begin
              state_d = PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_CHK;
              cnt_d   = CW'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (!sync2_q) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            if (STABLE_SAMPLES == 1) begin
              state_d   = RELEASED;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = RELEASE_CHK;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASE_CHK: begin
          if (sync2_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state_o   = (state_q == PRESSED) || (state_q == RELEASE_CHK);
    press_o   = press_q;
    release_o = release_q;
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int            HW       = CLOG2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Cleared only by a fresh press, so a release bounce cannot re-arm the event.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (tick_i && state_o && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  logic unused_long_ticks;
  assign unused_long_ticks = ^LONG_TICKS;
  assign long_o            = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one shared sample tick feeding KEY_NUM channels.
// Define KEY_LONG_PRESS_EN to enable the long-press event on key_long.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int KEY_NUM        = 2,
  parameter int SCAN_CYCLES    = 4_000_000,
  parameter int STABLE_SAMPLES = 2,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int LONG_TICKS     = 50
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int            TW        = CLOG2(SCAN_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_CYCLES - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
    key_debounce_ch #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .LONG_TICKS     (LONG_TICKS)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_ni    (rst_n),
      .tick_i    (tick),
      .key_i     (key_in[k]),
      .state_o   (key_state[k]),
      .press_o   (key_press[k]),
      .release_o (key_release[k]),
      .long_o    (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a short scan period (10 cycles, 3 samples).
module tb_key_debounce;

  localparam int SCAN   = 10;
  localparam int STABLE = 3;
  localparam int LONG   = 8;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] key_in  = 2'b11;
  logic [1:0] key_state, key_press, key_release, key_long;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int press_cnt[2] = '{0, 0};
  int rel_cnt[2]   = '{0, 0};
  int long_cnt[2]  = '{0, 0};
  int long_cyc[2]  = '{0, 0};

  key_debounce #(
    .KEY_NUM        (2),
    .SCAN_CYCLES    (SCAN),
    .STABLE_SAMPLES (STABLE),
    .KEY_ACTIVE_LOW (1'b1),
    .LONG_TICKS     (LONG)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (key_press[k] === 1'b1)   press_cnt[k]++;
      if (key_release[k] === 1'b1) rel_cnt[k]++;
      if (key_long[k] === 1'b1) begin
        long_cnt[k]++;
        long_cyc[k] = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] key;
    int         cycles;
    logic [1:0] st;
    int         dp0, dp1, dr0, dr1;
  } vec_t;

  vec_t vecs[7];

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [1:0] pulses(input int which);
    case (which)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  // Waits up to maxc cycles for any pulse of the chosen kind; at = -1 on timeout.
  task automatic wait_any(input int which, input int maxc, output int at, output logic [1:0] seen);
    at   = -1;
    seen = 2'b00;
    for (int i = 0; i < maxc && at < 0; i++) begin
      step(1);
      if (pulses(which) != 2'b00) begin
        at   = cyc;
        seen = pulses(which);
      end
    end
  endtask

  initial begin
    int         p0, p1, r0, r1, l0, c0, at;
    logic [1:0] seen;
    logic       st1_seen;

    //                key    cyc  state  dp0 dp1 dr0 dr1
    vecs[0] = '{2'b11, 60, 2'b00, 0, 0, 0, 0};
    vecs[1] = '{2'b10, 50, 2'b01, 1, 0, 0, 0};
    vecs[2] = '{2'b11, 50, 2'b00, 0, 0, 1, 0};
    vecs[3] = '{2'b01, 50, 2'b10, 0, 1, 0, 0};
    vecs[4] = '{2'b11, 50, 2'b00, 0, 0, 0, 1};
    vecs[5] = '{2'b00, 50, 2'b11, 1, 1, 0, 0};
    vecs[6] = '{2'b11, 50, 2'b00, 0, 0, 1, 1};

    // Reset with keys released
    rst_n  = 1'b0;
    key_in = 2'b11;
    step(100);
    check("reset key_state", key_state, 0);
    check("reset key_press", key_press, 0);
    check("reset key_release", key_release, 0);
    check("reset key_long", key_long, 0);
    rst_n = 1'b1;
    p0 = press_cnt[0] + press_cnt[1];
    r0 = rel_cnt[0] + rel_cnt[1];
    step(100);
    check("post-reset press pulses", press_cnt[0] + press_cnt[1] - p0, 0);
    check("post-reset release pulses", rel_cnt[0] + rel_cnt[1] - r0, 0);
    check("post-reset key_state", key_state, 0);

    // Table-driven level/event steps
    for (int i = 0; i < 7; i++) begin
      p0 = press_cnt[0]; p1 = press_cnt[1];
      r0 = rel_cnt[0];   r1 = rel_cnt[1];
      key_in = vecs[i].key;
      step(vecs[i].cycles);
      check($sformatf("vec%0d key_state", i), key_state, vecs[i].st);
      check($sformatf("vec%0d press0 count", i), press_cnt[0] - p0, vecs[i].dp0);
      check($sformatf("vec%0d press1 count", i), press_cnt[1] - p1, vecs[i].dp1);
      check($sformatf("vec%0d release0 count", i), rel_cnt[0] - r0, vecs[i].dr0);
      check($sformatf("vec%0d release1 count", i), rel_cnt[1] - r1, vecs[i].dr1);
    end

    // Clean press on key 0: latency window, single pulse, channel 1 silent
    p0 = press_cnt[0]; p1 = press_cnt[1]; r1 = rel_cnt[1];
    c0 = cyc;
    key_in = 2'b10;
    wait_any(0, 40, at, seen);
    check_range("key0 press latency", (at < 0) ? -1 : at - c0, 21, 33);
    check("key0 press vector", seen, 2'b01);
    step(1);
    check("key0 press width", key_press[0], 0);
    step(30);
    check("key0 press count", press_cnt[0] - p0, 1);
    check("key0 state held", key_state[0], 1);
    check("key1 press silent", press_cnt[1] - p1, 0);
    check("key1 release silent", rel_cnt[1] - r1, 0);
    check("key1 state silent", key_state[1], 0);
    key_in = 2'b11;
    step(50);

    // Key 1 bouncing every 7 cycles never reaches three agreeing samples
    p1 = press_cnt[1]; r1 = rel_cnt[1];
    st1_seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (i < 200 && (i % 7) == 0) key_in[1] = ~key_in[1];
      if (i == 200) key_in[1] = 1'b1;
      step(1);
      if (key_state[1]) st1_seen = 1'b1;
    end
    check("bounce press count", press_cnt[1] - p1, 0);
    check("bounce release count", rel_cnt[1] - r1, 0);
    check("bounce key_state seen", st1_seen, 0);

    // Simultaneous press and release of both keys
    key_in = 2'b00;
    wait_any(0, 40, at, seen);
    check("simultaneous press vector", seen, 2'b11);
    step(80);
    key_in = 2'b11;
    wait_any(1, 40, at, seen);
    check("simultaneous release vector", seen, 2'b11);
    step(20);

    // Reset pulse while key 0 is pressed: no release, fresh press afterwards
    key_in = 2'b10;
    wait_any(0, 40, at, seen);
    check("pre-reset press seen", seen, 2'b01);
    step(10);
    r0 = rel_cnt[0];
    rst_n = 1'b0;
    step(1);
    check("mid reset key_state", key_state, 0);
    check("mid reset key_press", key_press, 0);
    check("mid reset key_release", key_release, 0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_any(0, 40, at, seen);
    check_range("re-press latency after reset", (at < 0) ? -1 : at - c0, 21, 33);
    check("re-press vector", seen, 2'b01);
    step(5);
    check("no release across reset", rel_cnt[0] - r0, 0);
    key_in = 2'b11;
    step(50);

    // Long hold on key 0
    l0 = long_cnt[0];
    key_in = 2'b10;
    wait_any(0, 40, at, seen);
    check("long-hold press vector", seen, 2'b01);
    step(170);
`ifdef KEY_LONG_PRESS_EN
    check("long pulse count", long_cnt[0] - l0, 1);
    check("long pulse delay from press", long_cyc[0] - at, SCAN * LONG);
`else
    check("long pulse count", long_cnt[0] - l0, 0);
    check("key_long level", key_long, 0);
`endif
    key_in = 2'b11;
    step(50);
`ifdef KEY_LONG_PRESS_EN
    check("long count after release", long_cnt[0] - l0, 1);
`else
    check("long count after release", long_cnt[0] + long_cnt[1], 0);
`endif
    check("final key_state", key_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-key debouncer and event generator for the board push-buttons.
- Sits directly upstream of the LED-toggle and key-consumer logic.
- Takes raw asynchronous key pins and produces a clean level per key plus single-cycle press and release event pulses.
- Replaces ad-hoc "sample every 20 ms and edge-detect" logic with a verified, parameterised stage.

Parameters:
- KEY_NUM, 2, number of key channels.
- SCAN_CYCLES, 4_000_000, clock cycles per sample tick (20 ms at 200 MHz); minimum 2.
- STABLE_SAMPLES, 2, consecutive agreeing ticks needed to accept a level change; minimum 1.
- KEY_ACTIVE_LOW, 1, 1 = a pressed key reads 0 on the pin.
- LONG_TICKS, 50, held ticks before the long-press event fires (1 s at defaults); used only with KEY_LONG_PRESS_EN.

Ports:
- sys_clk  input  1  system clock (200 MHz single-ended, after the IBUFGDS).
- rst_n  input  1  reset, synchronous, active-low.
- key_in  input  KEY_NUM  raw asynchronous key pins.
- key_state  output  KEY_NUM  debounced level, 1 = pressed.
- key_press  output  KEY_NUM  one-cycle pulse on an accepted press.
- key_release  output  KEY_NUM  one-cycle pulse on an accepted release.
- key_long  output  KEY_NUM  one-cycle long-press pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n sampled low at a sys_clk edge):
  - tick counter = 0; every FSM = RELEASED; agreement counters = 0.
  - Synchronizer flops load the released pin level (1 if KEY_ACTIVE_LOW), so no spurious press comes out of reset.
  - All outputs = 0.
- Reset asserted mid-operation aborts every state. No release pulse is generated for a key that was held.
- Synchronizer:
  - Two flops per key; the second stage is normalised to "pressed = 1" according to KEY_ACTIVE_LOW.
- Tick generator:
  - Counter of width clog2(SCAN_CYCLES) runs 0..SCAN_CYCLES-1.
  - tick = 1 for exactly one cycle when count == SCAN_CYCLES-1; count then wraps to 0.
  - The tick is shared by all channels.
- Per-key FSM, evaluated only on tick cycles (s = synchronized sample):
  - RELEASED: s=1 -> PRESS_CHK with cnt=1. If STABLE_SAMPLES==1, go directly to PRESSED and fire press.
  - PRESS_CHK: s=1 -> cnt+1; on reaching STABLE_SAMPLES, go to PRESSED and fire press. s=0 -> RELEASED, cnt=0 (bounce rejected, no event).
  - PRESSED: s=0 -> RELEASE_CHK with cnt=1. STABLE_SAMPLES==1 shortcut applies symmetrically.
  - RELEASE_CHK: s=0 -> cnt+1; on reaching STABLE_SAMPLES, go to RELEASED and fire release. s=1 -> PRESSED, cnt=0.
- Outputs:
  - All registered.
  - key_state = 1 in PRESSED and RELEASE_CHK.
  - Press and release pulses are asserted in the cycle after the deciding tick and last exactly one cycle.
  - key_state changes in the same cycle as its pulse.
- Latency from a clean pin edge to the pulse: between (STABLE_SAMPLES-1)*SCAN_CYCLES+3 and STABLE_SAMPLES*SCAN_CYCLES+3 cycles.
- Width rule: cnt width is clog2(STABLE_SAMPLES+1); it never exceeds STABLE_SAMPLES.
- Channels are fully independent. Simultaneous events on several keys produce simultaneous pulses.
- A press and a release can never fire for the same key in the same cycle.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width clog2(LONG_TICKS+1), cleared on entry to PRESSED.
  - The counter increments on ticks while in PRESSED or RELEASE_CHK and saturates at LONG_TICKS.
  - key_long pulses for one cycle when the counter first reaches LONG_TICKS: at most once per press, no auto-repeat.
  - A release before LONG_TICKS produces no long event.
- Undefined: no hold counter logic; key_long is tied to 0; the port list is unchanged.

Decomposition:
- Shared package/header holds:
  - the FSM state encoding constants (RELEASED=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3);
  - a CLOG2 helper function.
- Sub-module key_debounce_ch: one channel (synchronizer, FSM, agreement counter, optional hold counter) taking a shared tick input.
- The top instantiates the tick generator plus a generate loop of KEY_NUM key_debounce_ch instances.

Test Plan:
Bench settings: SCAN_CYCLES=10, STABLE_SAMPLES=3, LONG_TICKS=8, KEY_ACTIVE_LOW=1.
1. Reset with key_in=2'b11, held 100 cycles -> all outputs 0; no pulses after rst_n rises.
2. key_in[0] driven to 0 and held -> key_press[0] exactly one 1-cycle pulse, 21..33 cycles after the edge; key_state[0]=1 from then on; channel 1 silent.
3. key_in[1] toggles 0/1 every 7 cycles for 200 cycles, then holds 1 -> zero press and release pulses; key_state[1] stays 0.
4. Both keys pressed in the same cycle, then released together 100 cycles later -> key_press=2'b11 in one cycle, key_release=2'b11 in one cycle.
5. rst_n pulsed low for 1 cycle while key 0 is PRESSED -> key_state=0, no release pulse. With the key still held, a new press pulse follows 21..33 cycles after reset release.
6. With KEY_LONG_PRESS_EN, key 0 held 200 cycles -> key_long[0] pulses once, 80 cycles after key_press[0]. Second build without the macro: key_long stays 0.
